multi_adder_with_flow_control: RTL

- Parametrised successor to the two-operand valid/ready adder.
- Joins N operand channels, each with its own valid/ready handshake, into one transaction. Sums the operands at full precision and passes the result through a configurable-depth pipeline of registered stages with full backpressure.
- Sits between independent operand producers and a single result consumer. Sustains one sum per cycle when all producers and the consumer are active.

---
 rtl/multi_adder_with_flow_control.sv | 81 ++++++++
 1 files changed

// File: rtl/multi_adder_with_flow_control.sv
// Joins n_inputs valid/ready operand channels and sums them at full precision.
// Latency: n_stages cycles from the join handshake to sum_vld.
// Backpressure: per-stage ready chain with bubble collapse; all channels stall together.
module multi_adder_with_flow_control #(
  parameter int width       = 4,
  parameter int n_inputs    = 2,
  parameter int n_stages    = 1,
  parameter int signed_mode = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [n_inputs-1:0]                in_vld,
  output logic [n_inputs-1:0]                in_rdy,
  input  logic [n_inputs*width-1:0]          in_data,
  output logic                               sum_vld,
  input  logic                               sum_rdy,
  output logic [width+$clog2(n_inputs)-1:0]  sum_data
);

  localparam int sum_w = width + $clog2(n_inputs);

  logic [n_stages-1:0] stage_vld;
  logic [n_stages:0]   stage_rdy;
  logic [sum_w-1:0]    stage_dat [n_stages];
  logic                rdy_chain;
  logic                all_vld;
  logic                join_hs;
  logic [sum_w-1:0]    join_sum;

  // Ready is built with a running accumulator so no bit of stage_rdy feeds another.
  always_comb begin
    rdy_chain = sum_rdy;
    stage_rdy = '0;
    stage_rdy[n_stages] = sum_rdy;
    for (int k = n_stages - 1; k >= 0; k--) begin
      rdy_chain    = ~stage_vld[k] | rdy_chain;
      stage_rdy[k] = rdy_chain;
    end
  end

  assign all_vld = &in_vld;
  assign join_hs = all_vld & stage_rdy[0];
  assign in_rdy  = {n_inputs{join_hs}};

  always_comb begin
    join_sum = '0;
    for (int i = 0; i < n_inputs; i++) begin
      if (signed_mode != 0)
        join_sum = join_sum + sum_w'($signed(in_data[i*width +: width]));
      else
        join_sum = join_sum + sum_w'(in_data[i*width +: width]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_vld <= '0;
    end else begin
      if (stage_rdy[0])
        stage_vld[0] <= all_vld;
      for (int k = 1; k < n_stages; k++) begin
        if (stage_rdy[k])
          stage_vld[k] <= stage_vld[k-1];
      end
    end
  end

  // Data registers are not reset; their contents only matter under a set valid bit.
  always_ff @(posedge clk) begin
    if (join_hs)
      stage_dat[0] <= join_sum;
    for (int k = 1; k < n_stages; k++) begin
      if (stage_vld[k-1] && stage_rdy[k])
        stage_dat[k] <= stage_dat[k-1];
    end
  end

  assign sum_vld  = stage_vld[n_stages-1];
  assign sum_data = stage_dat[n_stages-1];

endmodule
